cpu_bus_arbiter: RTL and testbench
==================================

CPU_BUS_ARBITER -- requirements
Module: cpu_bus_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, giving the bus-watchdog limit in cycles (8-bit; used only when CPU_BUS_TIMEOUT_EN is defined).
REQ-002 SHALL have port clk_i, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_i, input, 1, reset; asynchronous, active-low.
REQ-004 SHALL have port if_req_i, input, 1, fetch request; held until acked or errored.
REQ-005 SHALL have port if_adr_i, input, 32, fetch address.
REQ-006 SHALL have port if_ack_o, output, 1, fetch transfer done.
REQ-007 SHALL have port d_req_i, input, 1, data request; held until acked or errored.
REQ-008 SHALL have port d_we_i, input, 1, data write enable.
REQ-009 SHALL have port d_sel_i, input, 4, data byte selects.
REQ-010 SHALL have port d_adr_i, input, 32, data address.
REQ-011 SHALL have port d_dat_i, input, 32, store data.
REQ-012 SHALL have port d_ack_o, output, 1, data transfer done.
REQ-013 SHALL have port rd_dat_o, output, 32, read data, shared by both requesters.
REQ-014 SHALL have port err_o, output, 1, error on the current transfer; valid to the granted requester only.
REQ-015 SHALL have ports wb_cyc_o/wb_stb_o/wb_we_o (output, 1 each), wb_sel_o (output, 4), wb_adr_o/wb_dat_o (output, 32 each), wb_dat_i (input, 32), wb_ack_i/wb_err_i (input, 1 each), forming a Wishbone classic master.

Function
REQ-016 SHALL implement FSM IDLE, GNT_I, GNT_D.
REQ-017 In IDLE, a request sampled at edge N SHALL move the FSM to GNT_x and assert registered wb_cyc_o/wb_stb_o from cycle N+1.
REQ-018 On simultaneous requests, arbitration SHALL be round-robin on a last_gnt register; a lone request always wins.
REQ-019 At grant the arbiter SHALL latch adr/we/sel/dat (fetch: we=0, sel=4'hF, dat=0); requester input changes during the cycle SHALL be ignored.
REQ-020 if_ack_o/d_ack_o SHALL equal wb_ack_i gated by the grant (combinational); rd_dat_o SHALL equal wb_dat_i.
REQ-021 On ack or err at edge M, the FSM SHALL return to IDLE and drop cyc/stb in cycle M+1, with one idle cycle minimum between transfers.
REQ-022 When wb_ack_i and wb_err_i are both high, err SHALL win: err_o=1, ack_o=0.
REQ-023 wb_ack_i/wb_err_i in IDLE SHALL be ignored.
REQ-024 A requester dropping its request mid-cycle SHALL NOT abort the bus cycle; the cycle completes normally.

Reset
REQ-025 While rst_i=0 (asynchronously), the FSM SHALL be IDLE, last_gnt=data, all outputs 0, and the watchdog counter 0.

Configuration
REQ-026 With CPU_BUS_TIMEOUT_EN defined, an 8-bit counter SHALL clear at grant and increment each GNT cycle.
REQ-027 If that counter reaches TIMEOUT_CYCLES without ack/err, err_o SHALL pulse for one cycle, cyc/stb SHALL drop, and the FSM SHALL return to IDLE.
REQ-028 Without CPU_BUS_TIMEOUT_EN, no counter SHALL exist and the cycle SHALL wait indefinitely.

Structure
REQ-029 The shared package cpu_pkg SHALL hold the FSM state typedef, requester IDs (REQ_IF=0, REQ_D=1), and the Wishbone width constants.
REQ-030 The two-way round-robin picker SHALL be sub-module cpu_bus_rr_pick (inputs: reqs, last_gnt; output: winner).

Verification
REQ-031 Fetch 0x1000 alone, slave acks 2 cycles after stb with 0xDEADBEEF -> wb_adr_o=0x1000, we=0, sel=F; if_ack_o=1 with rd_dat_o=0xDEADBEEF; d_ack_o stays 0.
REQ-032 Both requesters assert on the first edge after reset, each held for 3 transfers -> grant order I,D,I,D,I,D with one idle cycle between transfers.
REQ-033 Store adr 0x2004, sel 4'b0011, dat 0x12345678 -> wb_we_o=1, wb_sel_o=3, wb_dat_o=0x12345678; d_ack_o on ack.
REQ-034 Ack and err in the same cycle -> err_o=1, ack_o=0, FSM returns to IDLE.
REQ-035 Macro on, TIMEOUT_CYCLES=8, slave never acks -> err_o pulses 8 cycles after grant and cyc drops; macro off -> cyc held for 100 cycles.
REQ-036 rst_i driven low mid-transfer -> cyc/stb/ack go 0 without a clock edge; the first grant after reset goes to fetch.

Source files
------------

// File: rtl/cpu_bus_arbiter_pkg.sv
// Shared types and constants for the CPU bus arbiter (package cpu_pkg).
// Optional bus watchdog in the arbiter is enabled by defining CPU_BUS_TIMEOUT_EN.
package cpu_pkg;

  // Wishbone bus widths
  localparam int WB_ADR_W = 32;
  localparam int WB_DAT_W = 32;
  localparam int WB_SEL_W = 4;

  // Arbiter FSM states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } state_e;

  // Requester identifiers
  typedef logic req_id_t;
  localparam req_id_t REQ_IF = 1'b0;
  localparam req_id_t REQ_D  = 1'b1;

  // Map a requester id onto the FSM state that serves it
  function automatic state_e gnt_state(input req_id_t id);
    return (id == REQ_D) ? GNT_D : GNT_I;
  endfunction

endpackage

// File: rtl/cpu_bus_arbiter_if.sv
// Bundle of requester-side and Wishbone-side signals of the CPU bus arbiter.
// master: the arbiter's view; slave: the environment (CPU + Wishbone slave).
interface cpu_bus_arbiter_if;
  import cpu_pkg::*;

  logic                if_req_i;
  logic [WB_ADR_W-1:0] if_adr_i;
  logic                if_ack_o;
  logic                d_req_i;
  logic                d_we_i;
  logic [WB_SEL_W-1:0] d_sel_i;
  logic [WB_ADR_W-1:0] d_adr_i;
  logic [WB_DAT_W-1:0] d_dat_i;
  logic                d_ack_o;
  logic [WB_DAT_W-1:0] rd_dat_o;
  logic                err_o;
  logic                wb_cyc_o;
  logic                wb_stb_o;
  logic                wb_we_o;
  logic [WB_SEL_W-1:0] wb_sel_o;
  logic [WB_ADR_W-1:0] wb_adr_o;
  logic [WB_DAT_W-1:0] wb_dat_o;
  logic [WB_DAT_W-1:0] wb_dat_i;
  logic                wb_ack_i;
  logic                wb_err_i;

  modport master (
    input  if_req_i, if_adr_i, d_req_i, d_we_i, d_sel_i, d_adr_i, d_dat_i,
    input  wb_dat_i, wb_ack_i, wb_err_i,
    output if_ack_o, d_ack_o, rd_dat_o, err_o,
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o
  );

  modport slave (
    output if_req_i, if_adr_i, d_req_i, d_we_i, d_sel_i, d_adr_i, d_dat_i,
    output wb_dat_i, wb_ack_i, wb_err_i,
    input  if_ack_o, d_ack_o, rd_dat_o, err_o,
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o
  );

endinterface

// File: rtl/cpu_bus_rr_pick.sv
// Two-way round-robin picker: a lone request wins, a tie goes to the
// requester that was not granted last.
module cpu_bus_rr_pick
  import cpu_pkg::*;
(
  input  logic [1:0] reqs,      // {data, fetch}
  input  req_id_t    last_gnt,
  output req_id_t    winner
);

  // Winner selection
  always_comb begin
    winner = REQ_IF;
    if (reqs == 2'b11) begin
      winner = (last_gnt == REQ_IF) ? REQ_D : REQ_IF;
    end else if (reqs[1]) begin
      winner = REQ_D;
    end
  end

endmodule

// File: rtl/cpu_bus_arbiter.sv
// Fetch/data arbiter in front of a Wishbone classic master port.
// Optional watchdog: define CPU_BUS_TIMEOUT_EN to abort a cycle with an error
// pulse once it has waited TIMEOUT_CYCLES cycles without ack/err.
module cpu_bus_arbiter
  import cpu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                clk_i,
  input  logic                rst_i,   // asynchronous, active-low
  cpu_bus_arbiter_if.master   bus
);

  localparam logic [7:0] TO_LIM = 8'(TIMEOUT_CYCLES);

  state_e              state_q, state_d;
  req_id_t             last_gnt_q, last_gnt_d;
  logic                cyc_q, cyc_d;
  logic                we_q, we_d;
  logic [WB_SEL_W-1:0] sel_q, sel_d;
  logic [WB_ADR_W-1:0] adr_q, adr_d;
  logic [WB_DAT_W-1:0] dat_q, dat_d;

  req_id_t winner;
  logic    in_gnt;
  logic    bus_done;
  logic    timeout_hit;

  cpu_bus_rr_pick u_pick (
    .reqs     ({bus.d_req_i, bus.if_req_i}),
    .last_gnt (last_gnt_q),
    .winner   (winner)
  );

  assign in_gnt   = (state_q != IDLE);
  assign bus_done = bus.wb_ack_i | bus.wb_err_i;

`ifdef CPU_BUS_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;

  // Watchdog: held at zero while idle (so it is clear at grant), counts each granted cycle
  always_comb begin
    cnt_d = (state_q == IDLE) ? 8'd0 : cnt_q + 8'd1;
  end

  // Watchdog register
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) cnt_q <= 8'd0;
    else        cnt_q <= cnt_d;
  end

  // A completing slave response takes precedence over a coincident timeout
  assign timeout_hit = in_gnt && (cnt_q == TO_LIM) && !bus_done;
`else
  logic unused_timeout;
  assign unused_timeout = ^TO_LIM;
  assign timeout_hit    = 1'b0;
`endif

  // Next-state logic: grant from IDLE latching the winner's request, release on ack/err/timeout
  always_comb begin
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    cyc_d      = cyc_q;
    we_d       = we_q;
    sel_d      = sel_q;
    adr_d      = adr_q;
    dat_d      = dat_q;
    case (state_q)
      IDLE: begin
        if (bus.if_req_i || bus.d_req_i) begin
          state_d    = gnt_state(winner);
          last_gnt_d = winner;
          cyc_d      = 1'b1;
          if (winner == REQ_D) begin
            we_d  = bus.d_we_i;
            sel_d = bus.d_sel_i;
            adr_d = bus.d_adr_i;
            dat_d = bus.d_dat_i;
          end else begin
            we_d  = 1'b0;
            sel_d = '1;
            adr_d = bus.if_adr_i;
            dat_d = '0;
          end
        end
      end
      GNT_I, GNT_D: begin
        if (bus_done || timeout_hit) begin
          state_d = IDLE;
          cyc_d   = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        cyc_d   = 1'b0;
      end
    endcase
  end

  // State and latched bus-cycle registers
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= IDLE;
      last_gnt_q <= REQ_D;
      cyc_q      <= 1'b0;
      we_q       <= 1'b0;
      sel_q      <= '0;
      adr_q      <= '0;
      dat_q      <= '0;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
      cyc_q      <= cyc_d;
      we_q       <= we_d;
      sel_q      <= sel_d;
      adr_q      <= adr_d;
      dat_q      <= dat_d;
    end
  end

  assign bus.wb_cyc_o = cyc_q;
  assign bus.wb_stb_o = cyc_q;
  assign bus.wb_we_o  = we_q;
  assign bus.wb_sel_o = sel_q;
  assign bus.wb_adr_o = adr_q;
  assign bus.wb_dat_o = dat_q;

  // Responses go only to the granted requester; error beats ack
  assign bus.if_ack_o = (state_q == GNT_I) & bus.wb_ack_i & ~bus.wb_err_i;
  assign bus.d_ack_o  = (state_q == GNT_D) & bus.wb_ack_i & ~bus.wb_err_i;
  assign bus.err_o    = (in_gnt & bus.wb_err_i) | timeout_hit;
  // Read data is forced to zero while reset is held
  assign bus.rd_dat_o = rst_i ? bus.wb_dat_i : '0;

endmodule

// File: tb/tb_cpu_bus_arbiter.sv
// Bench for cpu_bus_arbiter: directed cases plus a randomized phase checked
// against a transaction-level round-robin model.
module tb_cpu_bus_arbiter;
  import cpu_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cpu_bus_arbiter_if bus ();

  cpu_bus_arbiter #(.TIMEOUT_CYCLES(8)) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus)
  );

  int      n_cmp = 0;
  int      n_bad = 0;
  req_id_t m_last = REQ_D;   // model of the last granted requester

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Round-robin rule at transaction level
  function automatic req_id_t pick(input bit pi, input bit pd, input req_id_t last);
    if (pi && pd) return (last == REQ_D) ? REQ_IF : REQ_D;
    return pd ? REQ_D : REQ_IF;
  endfunction

  task automatic set_d(input logic we, input logic [3:0] sel, input logic [31:0] adr,
                       input logic [31:0] dat);
    bus.d_we_i = we; bus.d_sel_i = sel; bus.d_adr_i = adr; bus.d_dat_i = dat;
  endtask

  // Wait (bounded) for the bus cycle to start; expects it on the first sampled cycle
  task automatic wait_cyc(input string tag, output bit seen);
    int waits;
    seen = 1'b0;
    waits = 0;
    while (!seen && waits < 4) begin
      @(negedge clk); #1;
      waits++;
      seen = bus.wb_cyc_o;
    end
    chk({tag, ".gnt_lat"}, waits, 1);
  endtask

  // One complete transfer for requester id, answered after lat wait cycles
  task automatic do_xfer(input string tag, input req_id_t id, input int lat, input bit ack,
                         input bit err, input logic [31:0] rdata, input bit keep,
                         input bit wiggle);
    logic [31:0] e_adr, e_dat;
    logic [3:0]  e_sel;
    logic        e_we;
    bit          seen;
    if (id == REQ_D) begin
      e_adr = bus.d_adr_i; e_dat = bus.d_dat_i; e_sel = bus.d_sel_i; e_we = bus.d_we_i;
    end else begin
      e_adr = bus.if_adr_i; e_dat = 32'h0; e_sel = 4'hF; e_we = 1'b0;
    end
    wait_cyc(tag, seen);
    if (seen) begin
      chk({tag, ".adr"}, bus.wb_adr_o, e_adr);
      chk({tag, ".we"},  bus.wb_we_o,  e_we);
      chk({tag, ".sel"}, bus.wb_sel_o, e_sel);
      chk({tag, ".dat"}, bus.wb_dat_o, e_dat);
      chk({tag, ".stb"}, bus.wb_stb_o, 1);
      for (int i = 0; i < lat; i++) begin
        @(negedge clk);
        if (wiggle && i == 0) begin
          bus.if_adr_i = ~bus.if_adr_i;
          set_d(~bus.d_we_i, ~bus.d_sel_i, ~bus.d_adr_i, ~bus.d_dat_i);
          if (id == REQ_D) bus.d_req_i = 1'b0; else bus.if_req_i = 1'b0;
        end
        #1;
        chk({tag, ".hold_cyc"}, bus.wb_cyc_o, 1);
        chk({tag, ".hold_adr"}, bus.wb_adr_o, e_adr);
        chk({tag, ".hold_dat"}, bus.wb_dat_o, e_dat);
      end
      bus.wb_ack_i = ack; bus.wb_err_i = err; bus.wb_dat_i = rdata;
      #1;
      chk({tag, ".if_ack"}, bus.if_ack_o, (id == REQ_IF) && ack && !err);
      chk({tag, ".d_ack"},  bus.d_ack_o,  (id == REQ_D) && ack && !err);
      chk({tag, ".err"},    bus.err_o,    err);
      chk({tag, ".rd_dat"}, bus.rd_dat_o, rdata);
      @(negedge clk);
      bus.wb_ack_i = 1'b0; bus.wb_err_i = 1'b0;
      if (!keep) begin
        if (id == REQ_D) bus.d_req_i = 1'b0; else bus.if_req_i = 1'b0;
      end
      #1;
      chk({tag, ".idle_cyc"}, bus.wb_cyc_o, 0);
      chk({tag, ".idle_stb"}, bus.wb_stb_o, 0);
    end
    m_last = id;
    $display("xfer %-10s id=%0d adr=%h we=%0d sel=%h lat=%0d ack=%0d err=%0d", tag, id,
             e_adr, e_we, e_sel, lat, ack, err);
  endtask

  initial begin
    bit      seen, pi, pd, keep, ack, err;
    req_id_t w;
    int      r, lat;

    bus.if_req_i = 1'b1; bus.if_adr_i = 32'h0; bus.d_req_i = 1'b0;
    set_d(1'b0, 4'h0, 32'h0, 32'h0);
    bus.wb_dat_i = 32'hFFFF_FFFF; bus.wb_ack_i = 1'b1; bus.wb_err_i = 1'b0;

    // Reset state, with a request and a stray ack present
    #12;
    chk("rst.cyc", bus.wb_cyc_o, 0);
    chk("rst.stb", bus.wb_stb_o, 0);
    chk("rst.we",  bus.wb_we_o, 0);
    chk("rst.sel", bus.wb_sel_o, 0);
    chk("rst.adr", bus.wb_adr_o, 0);
    chk("rst.dat", bus.wb_dat_o, 0);
    chk("rst.if_ack", bus.if_ack_o, 0);
    chk("rst.d_ack",  bus.d_ack_o, 0);
    chk("rst.err",    bus.err_o, 0);
    chk("rst.rd_dat", bus.rd_dat_o, 0);
    @(negedge clk);
    bus.wb_ack_i = 1'b0; bus.if_req_i = 1'b0; rst_n = 1'b1;
    m_last = REQ_D;

    // Lone fetch, ack two cycles after strobe
    @(negedge clk);
    bus.if_adr_i = 32'h0000_1000; bus.if_req_i = 1'b1;
    do_xfer("fetch", REQ_IF, 2, 1, 0, 32'hDEAD_BEEF, 0, 0);

    // Slave responses while idle are ignored
    bus.wb_ack_i = 1'b1; bus.wb_err_i = 1'b1;
    #1;
    chk("idle.err", bus.err_o, 0);
    chk("idle.if_ack", bus.if_ack_o, 0);
    chk("idle.d_ack", bus.d_ack_o, 0);
    @(negedge clk);
    bus.wb_ack_i = 1'b0; bus.wb_err_i = 1'b0;
    #1;
    chk("idle.cyc", bus.wb_cyc_o, 0);

    // Store
    set_d(1'b1, 4'b0011, 32'h0000_2004, 32'h1234_5678); bus.d_req_i = 1'b1;
    do_xfer("store", REQ_D, 1, 1, 0, 32'h0, 0, 0);

    // Both requesters held for three transfers each
    bus.if_adr_i = 32'h0000_4000; bus.if_req_i = 1'b1;
    set_d(1'b1, 4'hC, 32'h0000_8000, 32'hCAFE_0001); bus.d_req_i = 1'b1;
    pi = 1; pd = 1;
    for (int k = 0; k < 6; k++) begin
      w = pick(pi, pd, m_last);
      chk("rr.order", w, (k % 2 == 0) ? REQ_IF : REQ_D);
      keep = (k < 4);
      do_xfer("rr", w, k % 3, 1, 0, 32'h100 + k, keep, 0);
    end

    // Ack and err together: err wins
    bus.if_adr_i = 32'h0000_5000; bus.if_req_i = 1'b1;
    do_xfer("ackerr", REQ_IF, 0, 1, 1, 32'h5555_AAAA, 0, 0);

    // Requester changes inputs and drops request mid-cycle
    set_d(1'b0, 4'h5, 32'h0000_6000, 32'h6666_0000); bus.d_req_i = 1'b1;
    do_xfer("wiggle", REQ_D, 2, 1, 0, 32'h7777_0000, 0, 1);

    // Randomized traffic against the round-robin model
    pi = 0; pd = 0;
    for (int t = 0; t < 24; t++) begin
      if (!pi && ($urandom_range(0, 1) == 1)) begin
        pi = 1; bus.if_req_i = 1'b1; bus.if_adr_i = $urandom;
      end
      if (!pd && ($urandom_range(0, 1) == 1)) begin
        pd = 1; bus.d_req_i = 1'b1;
        set_d(1'($urandom_range(0, 1)), 4'($urandom_range(1, 15)), $urandom, $urandom);
      end
      if (!pi && !pd) begin
        pi = 1; bus.if_req_i = 1'b1; bus.if_adr_i = $urandom;
      end
      w    = pick(pi, pd, m_last);
      lat  = $urandom_range(0, 3);
      r    = $urandom_range(0, 7);
      err  = (r < 2);
      ack  = (r >= 1);
      keep = 1'($urandom_range(0, 1));
      do_xfer("rand", w, lat, ack, err, $urandom, keep, 0);
      if (w == REQ_D) begin
        pd = keep;
        if (keep) set_d(1'($urandom_range(0, 1)), 4'($urandom_range(1, 15)), $urandom, $urandom);
      end else begin
        pi = keep;
        if (keep) bus.if_adr_i = $urandom;
      end
    end
    bus.if_req_i = 1'b0; bus.d_req_i = 1'b0;
    @(negedge clk); @(negedge clk);

    // Slave never answers
    bus.if_adr_i = 32'h0000_9000; bus.if_req_i = 1'b1;
    wait_cyc("nores", seen);
`ifdef CPU_BUS_TIMEOUT_EN
    for (int k = 0; k < 8; k++) begin
      chk("to.err_low", bus.err_o, 0);
      @(negedge clk); #1;
    end
    chk("to.err_pulse", bus.err_o, 1);
    chk("to.if_ack", bus.if_ack_o, 0);
    @(negedge clk);
    bus.if_req_i = 1'b0;
    #1;
    chk("to.cyc_drop", bus.wb_cyc_o, 0);
    chk("to.err_end", bus.err_o, 0);
`else
    for (int k = 0; k < 100; k++) begin
      @(negedge clk); #1;
      chk("hold.cyc", bus.wb_cyc_o, 1);
      chk("hold.err", bus.err_o, 0);
    end
    bus.wb_ack_i = 1'b1;
    #1;
    chk("hold.if_ack", bus.if_ack_o, 1);
    @(negedge clk);
    bus.wb_ack_i = 1'b0; bus.if_req_i = 1'b0;
    #1;
    chk("hold.cyc_drop", bus.wb_cyc_o, 0);
`endif
    m_last = REQ_IF;

    // Reset mid-transfer, then both requesters pending as reset releases
    set_d(1'b1, 4'hF, 32'h0000_B000, 32'hB0B0_B0B0); bus.d_req_i = 1'b1;
    do_xfer("pre_rst", REQ_D, 0, 1, 0, 32'h0, 0, 0);
    bus.if_adr_i = 32'h0000_A000; bus.if_req_i = 1'b1;
    wait_cyc("arst", seen);
    @(negedge clk); #2;
    bus.wb_ack_i = 1'b1; rst_n = 1'b0;
    #1;
    chk("arst.cyc", bus.wb_cyc_o, 0);
    chk("arst.stb", bus.wb_stb_o, 0);
    chk("arst.if_ack", bus.if_ack_o, 0);
    chk("arst.adr", bus.wb_adr_o, 0);
    bus.d_req_i = 1'b1;
    @(negedge clk);
    bus.wb_ack_i = 1'b0; rst_n = 1'b1;
    m_last = REQ_D;
    w = pick(1, 1, m_last);
    do_xfer("post_rst", w, 1, 1, 0, 32'h1111_2222, 0, 0);
    do_xfer("post_rst", REQ_D, 0, 1, 0, 32'h3333_4444, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
